// File: rtl/mb_poll.sv
// rtl/mb_poll.sv - Modbus slave poll engine consuming port events
//
// Purpose: takes one event at a time from the port event queue, fetches and
// address-filters received frames, self-posts EXECUTE for accepted frames,
// runs the function handler with a timeout, and hands responses to the RTU
// transmitter.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   enable, slave_addr              stack enable (gates new events), own address
//   ev_valid, ev_code, ev_get       event queue consumer side
//   ev_post, ev_post_code           event queue producer side (EXECUTE)
//   rx_req/rx_ack/rx_ok/rx_addr/rx_func     frame fetch handshake with receiver
//   fn_start/fn_code/fn_done/fn_exc/fn_exc_code   function handler handshake
//   tx_start/tx_ack/tx_func/tx_exc_code     response handshake with transmitter
//   busy, rx_err_cnt                status: not idle, saturating bad-frame count

module mb_poll #(
  parameter int FN_TIMEOUT = 1024,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [7:0]       slave_addr,
  input  logic             ev_valid,
  input  logic [1:0]       ev_code,
  output logic             ev_get,
  output logic             ev_post,
  output logic [1:0]       ev_post_code,
  output logic             rx_req,
  input  logic             rx_ack,
  input  logic             rx_ok,
  input  logic [7:0]       rx_addr,
  input  logic [7:0]       rx_func,
  output logic             fn_start,
  output logic [7:0]       fn_code,
  input  logic             fn_done,
  input  logic             fn_exc,
  input  logic [7:0]       fn_exc_code,
  output logic             tx_start,
  input  logic             tx_ack,
  output logic [7:0]       tx_func,
  output logic [7:0]       tx_exc_code,
  output logic             busy,
  output logic [ERR_W-1:0] rx_err_cnt
);

  localparam int CNT_W = $clog2(FN_TIMEOUT + 1);

  localparam logic [1:0] EV_READY      = 2'd0;
  localparam logic [1:0] EV_FRAME_RECV = 2'd1;
  localparam logic [1:0] EV_EXECUTE    = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DISPATCH = 3'd1,
    S_RX_WAIT  = 3'd2,
    S_FN_WAIT  = 3'd3,
    S_TX_WAIT  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       code_q, code_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       func_q, func_d;
  logic             frame_valid_q, frame_valid_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic             ev_get_q, ev_get_d;
  logic             ev_post_q, ev_post_d;
  logic [1:0]       ev_post_code_q, ev_post_code_d;
  logic             rx_req_q, rx_req_d;
  logic             fn_start_q, fn_start_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_func_q, tx_func_d;
  logic [7:0]       tx_exc_code_q, tx_exc_code_d;
  logic             busy_q, busy_d;
  logic [ERR_W-1:0] rx_err_cnt_q, rx_err_cnt_d;

  logic addr_match;
  logic fn_finish;
  logic exc_now;
  logic [7:0] exc_code_now;

  // Broadcast (address 0) is accepted alongside our own address.
  assign addr_match   = (rx_addr == slave_addr) || (rx_addr == 8'h00);
  // Handler completes either by fn_done or by the timeout counter draining.
  assign fn_finish    = fn_done || (tmo_cnt_q == '0);
  assign exc_now      = fn_done ? fn_exc : 1'b1;
  assign exc_code_now = fn_done ? fn_exc_code : 8'h04;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      code_q         <= '0;
      addr_q         <= '0;
      func_q         <= '0;
      frame_valid_q  <= 1'b0;
      tmo_cnt_q      <= '0;
      ev_get_q       <= 1'b0;
      ev_post_q      <= 1'b0;
      ev_post_code_q <= '0;
      rx_req_q       <= 1'b0;
      fn_start_q     <= 1'b0;
      tx_start_q     <= 1'b0;
      tx_func_q      <= '0;
      tx_exc_code_q  <= '0;
      busy_q         <= 1'b0;
      rx_err_cnt_q   <= '0;
    end else begin
      state_q        <= state_d;
      code_q         <= code_d;
      addr_q         <= addr_d;
      func_q         <= func_d;
      frame_valid_q  <= frame_valid_d;
      tmo_cnt_q      <= tmo_cnt_d;
      ev_get_q       <= ev_get_d;
      ev_post_q      <= ev_post_d;
      ev_post_code_q <= ev_post_code_d;
      rx_req_q       <= rx_req_d;
      fn_start_q     <= fn_start_d;
      tx_start_q     <= tx_start_d;
      tx_func_q      <= tx_func_d;
      tx_exc_code_q  <= tx_exc_code_d;
      busy_q         <= busy_d;
      rx_err_cnt_q   <= rx_err_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (ev_valid && enable) state_d = S_DISPATCH;
      end
      S_DISPATCH: begin
        if (code_q == EV_FRAME_RECV) begin
          state_d = S_RX_WAIT;
        end else if (code_q == EV_EXECUTE && frame_valid_q) begin
          state_d = S_FN_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RX_WAIT: begin
        if (rx_ack) state_d = S_IDLE;
      end
      S_FN_WAIT: begin
        if (fn_finish) state_d = (addr_q == 8'h00) ? S_IDLE : S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (tx_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    code_d         = code_q;
    addr_d         = addr_q;
    func_d         = func_q;
    frame_valid_d  = frame_valid_q;
    tmo_cnt_d      = tmo_cnt_q;
    ev_get_d       = 1'b0;
    ev_post_d      = 1'b0;
    ev_post_code_d = ev_post_code_q;
    rx_req_d       = rx_req_q;
    fn_start_d     = 1'b0;
    tx_start_d     = tx_start_q;
    tx_func_d      = tx_func_q;
    tx_exc_code_d  = tx_exc_code_q;
    rx_err_cnt_d   = rx_err_cnt_q;
    busy_d         = (state_d != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (ev_valid && enable) begin
          ev_get_d = 1'b1;
          code_d   = ev_code;
        end
      end
      S_DISPATCH: begin
        if (code_q == EV_FRAME_RECV) begin
          rx_req_d = 1'b1;
        end else if (code_q == EV_EXECUTE && frame_valid_q) begin
          fn_start_d = 1'b1;
          tmo_cnt_d  = CNT_W'(FN_TIMEOUT);
        end
      end
      S_RX_WAIT: begin
        if (rx_ack) begin
          rx_req_d = 1'b0;
          if (!rx_ok) begin
            if (rx_err_cnt_q != '1) rx_err_cnt_d = rx_err_cnt_q + 1'b1;
          end else if (addr_match) begin
            addr_d         = rx_addr;
            func_d         = rx_func;
            frame_valid_d  = 1'b1;
            ev_post_d      = 1'b1;
            ev_post_code_d = EV_EXECUTE;
          end
        end
      end
      S_FN_WAIT: begin
        if (fn_finish) begin
          if (addr_q != 8'h00) begin
            tx_start_d    = 1'b1;
            tx_func_d     = exc_now ? (func_q | 8'h80) : func_q;
            tx_exc_code_d = exc_now ? exc_code_now : 8'h00;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
      end
      S_TX_WAIT: begin
        if (tx_ack) tx_start_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign ev_get       = ev_get_q;
  assign ev_post      = ev_post_q;
  assign ev_post_code = ev_post_code_q;
  assign rx_req       = rx_req_q;
  assign fn_start     = fn_start_q;
  assign fn_code      = func_q;
  assign tx_start     = tx_start_q;
  assign tx_func      = tx_func_q;
  assign tx_exc_code  = tx_exc_code_q;
  assign busy         = busy_q;
  assign rx_err_cnt   = rx_err_cnt_q;

  // EV_READY and FRAME_SENT share the default dispatch path back to idle.
  logic unused_ok;
  assign unused_ok = (EV_READY == 2'd0);

endmodule

// File: tb/tb_mb_poll.sv
// tb/tb_mb_poll.sv - directed self-checking bench for mb_poll

module tb_mb_poll;

  localparam int FN_TIMEOUT = 16;
  localparam int ERR_W      = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [7:0]       slave_addr;
  logic             ev_valid;
  logic [1:0]       ev_code;
  logic             ev_get;
  logic             ev_post;
  logic [1:0]       ev_post_code;
  logic             rx_req;
  logic             rx_ack;
  logic             rx_ok;
  logic [7:0]       rx_addr;
  logic [7:0]       rx_func;
  logic             fn_start;
  logic [7:0]       fn_code;
  logic             fn_done;
  logic             fn_exc;
  logic [7:0]       fn_exc_code;
  logic             tx_start;
  logic             tx_ack;
  logic [7:0]       tx_func;
  logic [7:0]       tx_exc_code;
  logic             busy;
  logic [ERR_W-1:0] rx_err_cnt;

  int vectors = 0;
  int errors  = 0;

  mb_poll #(.FN_TIMEOUT(FN_TIMEOUT), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .slave_addr(slave_addr),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_get(ev_get),
    .ev_post(ev_post), .ev_post_code(ev_post_code),
    .rx_req(rx_req), .rx_ack(rx_ack), .rx_ok(rx_ok), .rx_addr(rx_addr), .rx_func(rx_func),
    .fn_start(fn_start), .fn_code(fn_code), .fn_done(fn_done), .fn_exc(fn_exc),
    .fn_exc_code(fn_exc_code), .tx_start(tx_start), .tx_ack(tx_ack),
    .tx_func(tx_func), .tx_exc_code(tx_exc_code), .busy(busy), .rx_err_cnt(rx_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one event; returns after the dispatch edge.
  task automatic post_event(input logic [1:0] code, input string tag);
    ev_valid = 1'b1;
    ev_code  = code;
    tick();
    chk({tag, "_get"}, 32'(ev_get), 32'd1);
    ev_valid = 1'b0;
    tick();
  endtask

  // Full frame fetch; the ack is given in the cycle rx_req first rises.
  task automatic frame(input logic [7:0] a, input logic [7:0] f, input logic ok,
                       output logic posted);
    ev_valid = 1'b1;
    ev_code  = 2'd1;
    tick();
    ev_valid = 1'b0;
    tick();
    rx_ack  = 1'b1;
    rx_ok   = ok;
    rx_addr = a;
    rx_func = f;
    tick();
    rx_ack  = 1'b0;
    posted  = ev_post;
  endtask

  logic posted;
  logic any_post;
  logic any_get;
  logic any_tx;

  initial begin
    rst_n = 1'b0; enable = 1'b1; slave_addr = 8'h11;
    ev_valid = 1'b0; ev_code = 2'd0;
    rx_ack = 1'b0; rx_ok = 1'b0; rx_addr = 8'h00; rx_func = 8'h00;
    fn_done = 1'b0; fn_exc = 1'b0; fn_exc_code = 8'h00; tx_ack = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_ev_get", 32'(ev_get), 32'd0);
    chk("rst_ev_post", 32'(ev_post), 32'd0);
    chk("rst_rx_req", 32'(rx_req), 32'd0);
    chk("rst_fn_start", 32'(fn_start), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fn_code", 32'(fn_code), 32'd0);
    chk("rst_tx_func", 32'(tx_func), 32'd0);
    chk("rst_err_cnt", 32'(rx_err_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // EXECUTE with no frame latched behaves as READY
    post_event(2'd2, "noframe");
    chk("noframe_fn_start", 32'(fn_start), 32'd0);
    chk("noframe_busy", 32'(busy), 32'd0);

    // Own-address frame then execute, normal response
    frame(8'h11, 8'h03, 1'b1, posted);
    chk("own_post", 32'(posted), 32'd1);
    chk("own_post_code", 32'(ev_post_code), 32'd2);
    chk("own_rx_req_drop", 32'(rx_req), 32'd0);
    tick();
    chk("own_post_pulse", 32'(ev_post), 32'd0);
    post_event(2'd2, "own_exec");
    chk("own_fn_start", 32'(fn_start), 32'd1);
    chk("own_fn_code", 32'(fn_code), 32'h03);
    fn_done = 1'b1; fn_exc = 1'b0;
    tick();
    fn_done = 1'b0;
    chk("own_tx_start", 32'(tx_start), 32'd1);
    chk("own_tx_func", 32'(tx_func), 32'h03);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    chk("own_tx_drop", 32'(tx_start), 32'd0);
    chk("own_idle", 32'(busy), 32'd0);
    post_event(2'd3, "frame_sent");
    chk("frame_sent_busy", 32'(busy), 32'd0);

    // Broadcast: executes, no response
    frame(8'h00, 8'h06, 1'b1, posted);
    chk("bc_post", 32'(posted), 32'd1);
    post_event(2'd2, "bc_exec");
    chk("bc_fn_start", 32'(fn_start), 32'd1);
    chk("bc_fn_code", 32'(fn_code), 32'h06);
    fn_done = 1'b1;
    tick();
    fn_done = 1'b0;
    chk("bc_no_tx", 32'(tx_start), 32'd0);
    tick();
    chk("bc_no_tx2", 32'(tx_start), 32'd0);
    chk("bc_busy", 32'(busy), 32'd0);

    // Exception path
    frame(8'h11, 8'h03, 1'b1, posted);
    post_event(2'd2, "exc_exec");
    fn_done = 1'b1; fn_exc = 1'b1; fn_exc_code = 8'h02;
    tick();
    fn_done = 1'b0; fn_exc = 1'b0;
    chk("exc_tx_start", 32'(tx_start), 32'd1);
    chk("exc_tx_func", 32'(tx_func), 32'h83);
    chk("exc_tx_code", 32'(tx_exc_code), 32'h02);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;

    // Timeout: tx_start appears at fn_start + FN_TIMEOUT + 1
    frame(8'h11, 8'h04, 1'b1, posted);
    post_event(2'd2, "tmo_exec");
    chk("tmo_fn_start", 32'(fn_start), 32'd1);
    any_tx = 1'b0;
    for (int i = 0; i < FN_TIMEOUT; i++) begin
      tick();
      any_tx |= tx_start;
    end
    chk("tmo_early_tx", 32'(any_tx), 32'd0);
    tick();
    chk("tmo_tx_start", 32'(tx_start), 32'd1);
    chk("tmo_tx_func", 32'(tx_func), 32'h84);
    chk("tmo_tx_code", 32'(tx_exc_code), 32'h04);
    fn_done = 1'b1;
    tx_ack  = 1'b1;
    tick();
    tx_ack  = 1'b0;
    chk("tmo_tx_drop", 32'(tx_start), 32'd0);
    any_tx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      any_tx |= tx_start;
    end
    fn_done = 1'b0;
    chk("tmo_late_done", 32'(any_tx), 32'd0);

    // Stray rx_ack while idle is ignored
    rx_ack = 1'b1; rx_ok = 1'b0;
    tick(); tick();
    rx_ack = 1'b0;
    chk("stray_ack_cnt", 32'(rx_err_cnt), 32'd0);

    // CRC errors, counter saturation
    any_post = 1'b0;
    for (int i = 0; i < 300; i++) begin
      frame(8'h11, 8'h03, 1'b0, posted);
      any_post |= posted;
      if (i == 9) chk("crc_cnt_10", 32'(rx_err_cnt), 32'd10);
    end
    chk("crc_no_post", 32'(any_post), 32'd0);
    chk("crc_cnt_sat", 32'(rx_err_cnt), 32'd255);
    frame(8'h22, 8'h03, 1'b1, posted);
    chk("mismatch_no_post", 32'(posted), 32'd0);
    chk("mismatch_cnt", 32'(rx_err_cnt), 32'd255);

    // Enable gating
    enable = 1'b0; ev_valid = 1'b1; ev_code = 2'd0;
    any_get = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      any_get |= ev_get;
    end
    chk("en_no_get", 32'(any_get), 32'd0);
    chk("en_idle", 32'(busy), 32'd0);
    enable = 1'b1;
    tick();
    chk("en_get", 32'(ev_get), 32'd1);
    ev_valid = 1'b0;
    tick(); tick();

    // Reset during TX_WAIT
    frame(8'h11, 8'h01, 1'b1, posted);
    post_event(2'd2, "rst_exec");
    fn_done = 1'b1;
    tick();
    fn_done = 1'b0;
    chk("rsttx_tx_start", 32'(tx_start), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rsttx_async_tx", 32'(tx_start), 32'd0);
    chk("rsttx_async_busy", 32'(busy), 32'd0);
    chk("rsttx_async_cnt", 32'(rx_err_cnt), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("rsttx_busy_after", 32'(busy), 32'd0);
    chk("rsttx_tx_after", 32'(tx_start), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
